// File: rtl/tx_frame_ctrl_pkg.sv
// Shared types and constants for the transmit framing controller.
// Build option TX_FRAME_PARITY_EN adds an even-parity bit to every frame.
package tx_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Start + data + stop, plus one parity bit when the option is built in.
  function automatic int frame_bits(input int data_bits);
`ifdef TX_FRAME_PARITY_EN
    return data_bits + 3;
`else
    return data_bits + 2;
`endif
  endfunction

endpackage

// File: rtl/tx_frame_ctrl_if.sv
// Payload handshake plus shift-register control bundle for tx_frame_ctrl.
// The producer side uses the master modport, the controller the slave modport.
interface tx_frame_ctrl_if
  import tx_frame_pkg::*;
#(
  parameter int DATA_BITS = 8
);
  localparam int FRAME_BITS = frame_bits(DATA_BITS);

  logic [DATA_BITS-1:0]  data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic [FRAME_BITS-1:0] frame_out;
  logic                  load_enable;
  logic                  shift_enable;
  logic                  tx_busy;
  logic                  frame_done;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  frame_out,
    input  load_enable,
    input  shift_enable,
    input  tx_busy,
    input  frame_done
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output frame_out,
    output load_enable,
    output shift_enable,
    output tx_busy,
    output frame_done
  );

endinterface

// File: rtl/tx_frame_ctrl_flex_counter.sv
// Rollover counter with synchronous clear and count enable; the flag is
// high while the count sits at its rollover value.
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_countEnable,
  input  logic [WIDTH-1:0] i_rolloverVal,
  output logic [WIDTH-1:0] o_count,
  output logic             o_rolloverFlag
);

  logic [WIDTH-1:0] r_count;

  // Wraps to zero after the rollover value, so it never exceeds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_countEnable) begin
      if (r_count == i_rolloverVal) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + WIDTH'(1);
      end
    end
  end

  assign o_count        = r_count;
  assign o_rolloverFlag = (r_count == i_rolloverVal);

endmodule

// File: rtl/tx_frame_ctrl.sv
// Serial transmit framing controller: captures a word, builds start/data/stop
// (optional parity with TX_FRAME_PARITY_EN) and paces the shift-register strobes.
module tx_frame_ctrl
  import tx_frame_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic          clk,
  input  logic          rst,
  tx_frame_ctrl_if.slave bus
);

  localparam int FRAME_BITS = frame_bits(DATA_BITS);
  localparam int CYC_W      = $clog2(CLKS_PER_BIT);
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CYC_W-1:0] CYC_TERM = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_TERM = BIT_W'(FRAME_BITS - 1);

  state_t                r_state;
  state_t                w_nextState;
  logic [FRAME_BITS-1:0] r_frame;

  logic             w_dataReady;
  logic             w_loadEnable;
  logic             w_shiftEnable;
  logic             w_txBusy;
  logic             w_frameDone;
  logic             w_accept;
  logic             w_countClear;
  logic             w_cycleEnable;
  logic [CYC_W-1:0] w_cycleCount;
  logic             w_cycleRoll;
  logic [BIT_W-1:0] w_bitCount;
  logic             w_bitRoll;
  logic             w_unusedCounts;

  // Data goes out LSB-first, so data_in[0] sits just below the start bit.
  function automatic logic [FRAME_BITS-1:0] buildFrame(input logic [DATA_BITS-1:0] data);
    logic [FRAME_BITS-1:0] f;
    f = '1;
    f[FRAME_BITS-1] = START_BIT;
    for (int i = 0; i < DATA_BITS; i++) begin
      f[FRAME_BITS-2-i] = data[i];
    end
`ifdef TX_FRAME_PARITY_EN
    f[1] = ^data;
`endif
    f[0] = STOP_BIT;
    return f;
  endfunction

  assign w_accept      = (r_state == IDLE) && bus.data_valid;
  assign w_countClear  = (r_state == LOAD);
  assign w_cycleEnable = (r_state == SHIFT);

  flex_counter #(.WIDTH(CYC_W)) u_cycleCounter (
    .clk            (clk),
    .rst            (rst),
    .i_clear        (w_countClear),
    .i_countEnable  (w_cycleEnable),
    .i_rolloverVal  (CYC_TERM),
    .o_count        (w_cycleCount),
    .o_rolloverFlag (w_cycleRoll)
  );

  flex_counter #(.WIDTH(BIT_W)) u_bitCounter (
    .clk            (clk),
    .rst            (rst),
    .i_clear        (w_countClear),
    .i_countEnable  (w_shiftEnable),
    .i_rolloverVal  (BIT_TERM),
    .o_count        (w_bitCount),
    .o_rolloverFlag (w_bitRoll)
  );

  // Only the terminal flags steer the FSM; the raw counts are not consumed.
  assign w_unusedCounts = ^{w_cycleCount, w_bitCount};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_dataReady   = 1'b0;
    w_loadEnable  = 1'b0;
    w_shiftEnable = 1'b0;
    w_txBusy      = 1'b0;
    w_frameDone   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_dataReady = 1'b1;
        if (bus.data_valid) begin
          w_nextState = LOAD;
        end
      end
      LOAD: begin
        w_loadEnable = 1'b1;
        w_txBusy     = 1'b1;
        w_nextState  = SHIFT;
      end
      SHIFT: begin
        w_txBusy = 1'b1;
        if (w_cycleRoll) begin
          w_shiftEnable = 1'b1;
          if (w_bitRoll) begin
            w_frameDone = 1'b1;
            w_nextState = IDLE;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Reset value of all ones matches the idle-high line of the shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame <= '1;
    end else if (w_accept) begin
      r_frame <= buildFrame(bus.data_in);
    end
  end

  assign bus.data_ready   = w_dataReady;
  assign bus.frame_out    = r_frame;
  assign bus.load_enable  = w_loadEnable;
  assign bus.shift_enable = w_shiftEnable;
  assign bus.tx_busy      = w_txBusy;
  assign bus.frame_done   = w_frameDone;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Directed-plus-random bench for tx_frame_ctrl; strobe timing and line bits
// are predicted from the frame rules and checked with immediate assertions.
module tb_tx_frame_ctrl;
  import tx_frame_pkg::*;

  localparam int D  = 8;
  localparam int C  = 4;
  localparam int F  = frame_bits(D);
  localparam int FC = F * C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  tx_frame_ctrl_if #(.DATA_BITS(D)) bus ();

  tx_frame_ctrl #(
    .DATA_BITS    (D),
    .CLKS_PER_BIT (C)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Frame as the line should carry it: start, data LSB-first, parity, stop.
  function automatic logic [F-1:0] modelFrame(input logic [D-1:0] word);
    logic [F-1:0] acc;
    int ones;
    acc  = '0;
    ones = 0;
    acc  = {acc[F-2:0], 1'b0};
    for (int i = 0; i < D; i++) begin
      acc  = {acc[F-2:0], word[i]};
      ones = ones + int'(word[i]);
    end
`ifdef TX_FRAME_PARITY_EN
    acc = {acc[F-2:0], ((ones % 2) == 1)};
`endif
    acc = {acc[F-2:0], 1'b1};
    return acc;
  endfunction

  // {ready, load, shift, busy, done} for cycle n after a handshake in cycle 0.
  function automatic logic [4:0] expVec(input int n);
    logic ready, load, shift, busy, done;
    ready = (n == 0) || (n == FC + 2);
    load  = (n == 1);
    shift = (n > 1) && (n <= FC + 1) && (((n - 1) % C) == 0);
    busy  = (n >= 1) && (n <= FC + 1);
    done  = (n == FC + 1);
    return {ready, load, shift, busy, done};
  endfunction

  function automatic logic [4:0] obsVec();
    return {bus.data_ready, bus.load_enable, bus.shift_enable, bus.tx_busy, bus.frame_done};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Handshake in the current cycle, then follow the frame cycle by cycle.
  task automatic applyStimulus(input logic [D-1:0] word, input bit holdValid, input int abortAt);
    logic [F-1:0] sr;
    logic [F:0]   lineBits;
    int           nLine;
    checkOutput($sformatf("idle_before_%0h", word), obsVec(), expVec(0));
    bus.data_valid = 1'b1;
    bus.data_in    = word;
    sr       = '1;
    lineBits = '0;
    nLine    = 0;
    for (int n = 1; n <= FC + 2; n++) begin
      @(posedge clk);
      #1;
      bus.data_valid = holdValid;
      bus.data_in    = D'($urandom);
      checkOutput($sformatf("strobes_cycle_%0d", n), obsVec(), expVec(n));
      if (n == 1) checkOutput("frame_capture", bus.frame_out, modelFrame(word));
      if (bus.load_enable) begin
        sr       = bus.frame_out;
        lineBits = {lineBits[F-1:0], sr[F-1]};
        nLine++;
      end
      if (bus.shift_enable) begin
        sr       = {sr[F-2:0], 1'b1};
        lineBits = {lineBits[F-1:0], sr[F-1]};
        nLine++;
      end
      if (n == abortAt) begin
        bus.data_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("abort_strobes", obsVec(), 5'b10000);
        checkOutput("abort_frame", bus.frame_out, {F{1'b1}});
        @(posedge clk);
        #1;
        checkOutput("abort_hold", obsVec(), 5'b10000);
        rst = 1'b0;
        return;
      end
    end
    checkOutput("line_bits", lineBits, {modelFrame(word), 1'b1});
    checkOutput("line_count", nLine, F + 1);
  endtask

  initial begin
    bus.data_valid = 1'b1;
    bus.data_in    = D'($urandom);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_strobes", obsVec(), 5'b10000);
    checkOutput("reset_frame", bus.frame_out, {F{1'b1}});
    rst = 1'b0;
    bus.data_valid = 1'b0;

    applyStimulus(8'hA5, 1'b0, 0);
`ifdef TX_FRAME_PARITY_EN
    checkOutput("frame_A5_const", bus.frame_out, 64'h295);
`else
    checkOutput("frame_A5_const", bus.frame_out, 64'h14B);
`endif

    applyStimulus(8'h07, 1'b0, 0);
`ifdef TX_FRAME_PARITY_EN
    checkOutput("frame_07_const", bus.frame_out, 64'h383);
    checkOutput("parity_bit_07", bus.frame_out[1], 1'b1);
`else
    checkOutput("frame_07_const", bus.frame_out, 64'h1C1);
    checkOutput("bit1_is_d7_07", bus.frame_out[1], 1'b0);
`endif

    for (int i = 0; i < 3; i++) begin
      applyStimulus(D'($urandom), (i < 2), 0);
    end

    applyStimulus(D'($urandom), 1'b0, 20);
    applyStimulus(D'($urandom), 1'b0, 0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(D'($urandom), 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
